portb_uart_tx: RTL and testbench

Serial output stage downstream of the CPU's port-B register. Each port-B write strobe pushes the written byte into a small FIFO. An 8N1 UART transmitter drains the FIFO onto a single TX pin, so program output can be observed on a host terminal. The block is instantiated in the top level beside the CPU core and needs no changes to the core's datapath.

---
 rtl/portb_uart_tx_if.sv | 20 ++
 rtl/portb_uart_tx.sv | 137 +++++++++++++
 tb/tb_portb_uart_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/portb_uart_tx_if.sv
// Port-B write bus and UART status bundle for portb_uart_tx.
interface portb_uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx;
    logic       busy;
    logic       empty;
    logic       full;
    logic       overflow;

    modport master (
        output wr_en, wr_data,
        input  tx, busy, empty, full, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output tx, busy, empty, full, overflow
    );
endinterface

// File: rtl/portb_uart_tx.sv
// Port-B byte FIFO drained by an 8N1 UART transmitter onto a single TX pin.
// Frames run back to back while the FIFO holds data.
module portb_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    portb_uart_tx_if.slave bus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_n;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                ovf_q;
    logic [BAUD_W-1:0]   baud_cnt, baud_n;
    logic [2:0]          bit_idx, bit_n;
    logic [7:0]          shift, shift_n;
    logic                tx_q, tx_n;
    logic                pop, push, baud_done, has_data;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign has_data  = (count != '0);
    // A full FIFO still takes a write when the head is popped on the same edge.
    assign push      = bus.wr_en && ((count != CNT_FULL) || pop);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        baud_n  = BAUD_W'(baud_cnt + 1'b1);
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                baud_n = '0;
                if (has_data) begin
                    pop     = 1'b1;
                    state_n = START;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_done) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        bit_n   = 3'(bit_idx + 1'b1);
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_done) begin
                    baud_n = '0;
                    if (has_data) begin
                        pop     = 1'b1;
                        state_n = START;
                        shift_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_q    <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
            if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            if (push && !pop)      count <= CNT_W'(count + 1'b1);
            else if (pop && !push) count <= CNT_W'(count - 1'b1);
            if (bus.wr_en && !push) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = (state != IDLE);
    assign bus.empty    = (count == '0);
    assign bus.full     = (count == CNT_FULL);
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_portb_uart_tx.sv
// Directed self-checking bench for portb_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_portb_uart_tx;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [7:0] exp_b [8];

    portb_uart_tx_if u_if ();

    portb_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        u_if.wr_en  = 1'b0;
        u_if.wr_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Logs tx while busy; checks busy length and each bit at its mid-point.
    task automatic watch(input int n);
        logic txlog [$];
        bit   seen;
        int   idx;
        logic e;
        seen = 1'b0;
        for (int c = 0; c < 40 * n + 100; c++) begin
            @(negedge clk);
            if (u_if.busy) begin
                seen = 1'b1;
                txlog.push_back(u_if.tx);
            end else if (seen) begin
                break;
            end
        end
        check("busy_len", 32'(txlog.size()), 32'(40 * n));
        if (txlog.size() > 0) check("start_edge", 32'(txlog[0]), 32'd0);
        for (int f = 0; f < n; f++) begin
            for (int j = 0; j < 10; j++) begin
                idx = 40 * f + 4 * j + 2;
                if (j == 0)      e = 1'b0;
                else if (j == 9) e = 1'b1;
                else             e = exp_b[f][j-1];
                check($sformatf("frame%0d_bit%0d", f, j),
                      (idx < txlog.size()) ? 32'(txlog[idx]) : 32'hx, 32'(e));
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.wr_data = 8'h00;
        do_reset();
        @(negedge clk);
        check("rst_tx",    32'(u_if.tx), 32'd1);
        check("rst_busy",  32'(u_if.busy), 32'd0);
        check("rst_empty", 32'(u_if.empty), 32'd1);
        check("rst_full",  32'(u_if.full), 32'd0);
        check("rst_ovf",   32'(u_if.overflow), 32'd0);

        // Idle stability
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_tx",    32'(u_if.tx), 32'd1);
            check("idle_busy",  32'(u_if.busy), 32'd0);
            check("idle_empty", 32'(u_if.empty), 32'd1);
        end

        // Single byte
        do_reset();
        exp_b[0] = 8'h55;
        fork
            begin
                u_if.wr_en = 1'b1; u_if.wr_data = 8'h55;
                @(negedge clk);
                u_if.wr_en = 1'b0;
                check("wr_lat_empty", 32'(u_if.empty), 32'd0);
                check("wr_lat_tx",    32'(u_if.tx), 32'd1);
                check("wr_lat_busy",  32'(u_if.busy), 32'd0);
                @(negedge clk);
                check("pop_empty", 32'(u_if.empty), 32'd1);
                check("pop_tx",    32'(u_if.tx), 32'd0);
                check("pop_busy",  32'(u_if.busy), 32'd1);
            end
            watch(1);
        join
        check("single_tx_idle", 32'(u_if.tx), 32'd1);

        // Back-to-back
        do_reset();
        exp_b[0] = 8'hA3; exp_b[1] = 8'h0F;
        fork
            begin
                u_if.wr_en = 1'b1; u_if.wr_data = 8'hA3;
                @(negedge clk);
                u_if.wr_data = 8'h0F;
                @(negedge clk);
                u_if.wr_en = 1'b0;
            end
            watch(2);
        join
        check("b2b_empty", 32'(u_if.empty), 32'd1);

        // Full / overflow
        do_reset();
        for (int i = 0; i < 5; i++) exp_b[i] = 8'(i + 1);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    u_if.wr_en = 1'b1; u_if.wr_data = 8'(i + 1);
                    @(negedge clk);
                    if (i == 4) begin
                        check("full_5th",   32'(u_if.full), 32'd1);
                        check("ovf_before", 32'(u_if.overflow), 32'd0);
                    end
                end
                u_if.wr_en = 1'b0;
                check("ovf_set",   32'(u_if.overflow), 32'd1);
                check("full_6th",  32'(u_if.full), 32'd1);
            end
            watch(5);
        join
        check("ovf_sticky", 32'(u_if.overflow), 32'd1);
        check("ovf_empty",  32'(u_if.empty), 32'd1);

        // Write on the STOP->START pop edge of a full FIFO
        do_reset();
        for (int i = 0; i < 5; i++) exp_b[i] = 8'(i + 1);
        exp_b[5] = 8'h77;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    u_if.wr_en = 1'b1; u_if.wr_data = 8'(i + 1);
                    @(negedge clk);
                end
                u_if.wr_en = 1'b0;
                repeat (36) @(negedge clk);
                check("pre_full", 32'(u_if.full), 32'd1);
                u_if.wr_en = 1'b1; u_if.wr_data = 8'h77;
                @(negedge clk);
                u_if.wr_en = 1'b0;
                check("coin_ovf",  32'(u_if.overflow), 32'd0);
                check("coin_full", 32'(u_if.full), 32'd1);
            end
            watch(6);
        join
        check("coin_ovf_end", 32'(u_if.overflow), 32'd0);

        // Reset mid-frame during DATA bit 3
        do_reset();
        for (int i = 0; i < 6; i++) begin
            u_if.wr_en = 1'b1; u_if.wr_data = 8'(i + 1);
            @(negedge clk);
        end
        u_if.wr_en = 1'b0;
        repeat (13) @(negedge clk);
        check("mid_tx_bit3", 32'(u_if.tx), 32'd0);
        check("mid_busy",    32'(u_if.busy), 32'd1);
        check("mid_ovf",     32'(u_if.overflow), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx",    32'(u_if.tx), 32'd1);
        check("abort_busy",  32'(u_if.busy), 32'd0);
        check("abort_empty", 32'(u_if.empty), 32'd1);
        check("abort_ovf",   32'(u_if.overflow), 32'd0);
        check("abort_full",  32'(u_if.full), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("post_rst_tx",   32'(u_if.tx), 32'd1);
            check("post_rst_busy", 32'(u_if.busy), 32'd0);
        end
        exp_b[0] = 8'h5A;
        fork
            begin
                u_if.wr_en = 1'b1; u_if.wr_data = 8'h5A;
                @(negedge clk);
                u_if.wr_en = 1'b0;
            end
            watch(1);
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
